// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        VALID,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN_C = 32'h0000_0013;
    localparam logic [31:0] INSN_BYTES = 32'd4;

    // Redirect targets are word addresses; the two low bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/grant + response-valid bus.
interface ifetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    // Fetch unit side
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Memory side
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request
// outstanding and presents either a fetched instruction or a NOP bubble.
module ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = NOP_INSN_C
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stallF,
    input  logic                 pc_redirect,
    input  logic [31:0]          pc_target,
    ifetch_unit_if.master        imem,
    output logic [31:0]          instF,
    output logic [31:0]          PCF,
    output logic                 validF
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ibuf_q, ibuf_d;
    logic [31:0]  target_aligned;
    logic [31:0]  pc_plus4;

    assign target_aligned = word_align(pc_target);
    assign pc_plus4       = pc_q + INSN_BYTES;  // wraps modulo 2^32

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            ibuf_q  <= NOP_INSN;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // Next-state, next-PC and buffer-capture logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        unique case (state_q)
            ISSUE: begin
                // An ungranted request may retarget freely.
                if (pc_redirect) pc_d = target_aligned;
                if (imem.gnt)    state_d = pc_redirect ? DISCARD : WAIT;
            end
            WAIT: begin
                if (pc_redirect) begin
                    pc_d    = target_aligned;
                    // Data arriving with a redirect is stale; otherwise drain it.
                    state_d = imem.rvalid ? ISSUE : DISCARD;
                end else if (imem.rvalid) begin
                    ibuf_d  = imem.rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                // Redirect outranks stall.
                if (pc_redirect) begin
                    pc_d    = target_aligned;
                    state_d = ISSUE;
                end else if (!stallF) begin
                    pc_d    = pc_plus4;
                    state_d = ISSUE;
                end
            end
            DISCARD: begin
                if (pc_redirect) pc_d = target_aligned;
                if (imem.rvalid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    // Bus request and IF/ID outputs; bubble unless presenting a fetched word.
    always_comb begin
        imem.req  = 1'b0;
        imem.addr = pc_q;
        instF     = NOP_INSN;
        PCF       = pc_q;
        validF    = 1'b0;
        unique case (state_q)
            // Gated by reset so no request escapes while reset is held.
            ISSUE:   imem.req = reset;
            VALID: begin
                instF  = ibuf_q;
                validF = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle-exact vector table plus hand-written sequences,
// with fetched instructions checked through a scoreboard queue.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] instF;
    logic [31:0] PCF;
    logic        validF;

    ifetch_unit_if imem_bus ();

    ifetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSN (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stallF),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .imem        (imem_bus),
        .instF       (instF),
        .PCF         (PCF),
        .validF      (validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        gnt;
        logic        rvalid;
        logic        redir;
        logic        stall;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic        push;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcf;
        logic [31:0] e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    function automatic vec_t mk(string nm, logic gnt, logic rv, logic rd, logic st,
                                logic [31:0] tgt, logic [31:0] rdata, logic push,
                                logic e_req, logic [31:0] e_addr, logic e_valid,
                                logic [31:0] e_pcf, logic [31:0] e_inst);
        vec_t v;
        v.nm = nm; v.gnt = gnt; v.rvalid = rv; v.redir = rd; v.stall = st;
        v.tgt = tgt; v.rdata = rdata; v.push = push;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pcf = e_pcf; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_out(string nm, logic e_req, logic [31:0] e_addr, logic e_valid,
                             logic [31:0] e_pcf, logic [31:0] e_inst);
        cmp({nm, ".req"}, {31'd0, imem_bus.req}, {31'd0, e_req});
        if (e_req) cmp({nm, ".addr"}, imem_bus.addr, e_addr);
        cmp({nm, ".validF"}, {31'd0, validF}, {31'd0, e_valid});
        cmp({nm, ".PCF"}, PCF, e_pcf);
        cmp({nm, ".instF"}, instF, e_inst);
    endtask

    // Pops the scoreboard on the first cycle of each presented instruction.
    task automatic monitor();
        sb_t e;
        if (validF === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb.unexpected: got pc %h insn %h expected none", PCF, instF);
            end else begin
                e = sb.pop_front();
                cmp("sb.pc", PCF, e.pc);
                cmp("sb.insn", instF, e.insn);
            end
        end
        prev_valid = (validF === 1'b1);
    endtask

    task automatic drive(logic gnt, logic rv, logic rd, logic st,
                         logic [31:0] tgt, logic [31:0] rdata);
        imem_bus.gnt    = gnt;
        imem_bus.rvalid = rv;
        pc_redirect     = rd;
        stallF          = st;
        pc_target       = tgt;
        imem_bus.rdata  = rdata;
    endtask

    initial begin
        sb_t e;
        int  waited;
        // name gnt rv rd st tgt rdata push | req addr valid pcf inst
        vecs.push_back(mk("t0_iss",  1,0,0,0, 0, 0, 0,             1, 32'h100, 0, 32'h100, NOP));
        vecs.push_back(mk("t0_wait", 0,1,0,0, 0, 32'hAAAA0001, 1,  0, 0,       0, 32'h100, NOP));
        vecs.push_back(mk("t0_val",  0,0,0,0, 0, 0, 0,             0, 0,       1, 32'h100, 32'hAAAA0001));
        vecs.push_back(mk("t1_iss",  1,0,0,0, 0, 0, 0,             1, 32'h104, 0, 32'h104, NOP));
        vecs.push_back(mk("t1_wait", 0,1,0,0, 0, 32'hAAAA0002, 1,  0, 0,       0, 32'h104, NOP));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("stall", 0,0,0,1, 0, 0, 0,           0, 0,       1, 32'h104, 32'hAAAA0002));
        vecs.push_back(mk("unstall", 0,0,0,0, 0, 0, 0,             0, 0,       1, 32'h104, 32'hAAAA0002));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("nognt", 0,0,0,0, 0, 0, 0,           1, 32'h108, 0, 32'h108, NOP));
        vecs.push_back(mk("nognt_rd", 0,0,1,0, 32'h3001, 0, 0,     1, 32'h108, 0, 32'h108, NOP));
        vecs.push_back(mk("rd_iss",  1,0,0,0, 0, 0, 0,             1, 32'h3000, 0, 32'h3000, NOP));
        vecs.push_back(mk("wait_rd", 0,0,1,0, 32'h2003, 0, 0,      0, 0,       0, 32'h3000, NOP));
        vecs.push_back(mk("disc",    0,0,0,0, 0, 0, 0,             0, 0,       0, 32'h2000, NOP));
        vecs.push_back(mk("disc_rv", 0,1,0,0, 0, 32'hDEAD0000, 0,  0, 0,       0, 32'h2000, NOP));
        vecs.push_back(mk("t2_iss",  1,0,0,0, 0, 0, 0,             1, 32'h2000, 0, 32'h2000, NOP));
        vecs.push_back(mk("t2_wait", 0,1,0,0, 0, 32'hBBBB0003, 1,  0, 0,       0, 32'h2000, NOP));
        vecs.push_back(mk("rd_st",   0,0,1,1, 32'hFFFFFFFC, 0, 0,  0, 0,       1, 32'h2000, 32'hBBBB0003));
        vecs.push_back(mk("t3_iss",  1,0,0,0, 0, 0, 0,             1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, NOP));
        vecs.push_back(mk("t3_wait", 0,1,0,0, 0, 32'hCCCC0004, 1,  0, 0,       0, 32'hFFFFFFFC, NOP));
        vecs.push_back(mk("t3_val",  0,0,0,0, 0, 0, 0,             0, 0,       1, 32'hFFFFFFFC, 32'hCCCC0004));
        vecs.push_back(mk("wrap_rv", 0,1,0,0, 0, 32'h55, 0,        1, 32'h0,   0, 32'h0,   NOP));
        vecs.push_back(mk("wrap_is", 1,0,0,0, 0, 0, 0,             1, 32'h0,   0, 32'h0,   NOP));
        vecs.push_back(mk("wait_st", 0,0,0,1, 0, 0, 0,             0, 0,       0, 32'h0,   NOP));
        vecs.push_back(mk("wait_rr", 0,1,1,0, 32'h400, 32'h66, 0,  0, 0,       0, 32'h0,   NOP));
        vecs.push_back(mk("iss_grd", 1,0,1,0, 32'h500, 0, 0,       1, 32'h400, 0, 32'h400, NOP));
        vecs.push_back(mk("disc_rr", 0,1,1,0, 32'h600, 32'h77, 0,  0, 0,       0, 32'h500, NOP));
        vecs.push_back(mk("t4_iss",  1,0,0,0, 0, 0, 0,             1, 32'h600, 0, 32'h600, NOP));

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_out("reset", 1'b0, 32'h0, 1'b0, RST_PC, NOP);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].redir, vecs[i].stall,
                  vecs[i].tgt, vecs[i].rdata);
            if (vecs[i].push) begin
                e.pc   = vecs[i].e_pcf;
                e.insn = vecs[i].rdata;
                sb.push_back(e);
            end
            @(negedge clk);
            check_out(vecs[i].nm, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_pcf, vecs[i].e_inst);
            monitor();
            @(posedge clk);
            #1;
        end

        // Async reset in the middle of WAIT: outputs return without a clock edge.
        drive(0, 0, 0, 0, 0, 0);
        #2;
        cmp("pre_rst.PCF", PCF, 32'h600);
        reset = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 1'b0, RST_PC, NOP);
        prev_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        e.pc   = RST_PC;
        e.insn = 32'h7777_0005;
        sb.push_back(e);
        @(negedge clk);
        check_out("post_rst", 1'b1, RST_PC, 1'b0, RST_PC, NOP);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 1, 0, 0, 0, 32'h7777_0005);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);

        // Bounded wait for the post-reset fetch to reach the scoreboard.
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(negedge clk);
            monitor();
            waited++;
        end
        cmp("sb.drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
